// File: rtl/memaccess_pkg.sv
// Shared types for the LC-3 memory-stage access unit: command modes, FSM states
// and the two mode-classification helpers used by the controller.
package memaccess_pkg;

  typedef enum logic [1:0] {
    MODE_LD  = 2'd0,
    MODE_LDI = 2'd1,
    MODE_ST  = 2'd2,
    MODE_STI = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_ACC  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic logic is_indirect(input mode_e m);
    return (m == MODE_LDI) || (m == MODE_STI);
  endfunction

  function automatic logic is_store(input mode_e m);
    return (m == MODE_ST) || (m == MODE_STI);
  endfunction

endpackage

// File: rtl/memaccess_wdog.sv
// Wait counter for one memory request: counts un-acknowledged req cycles and
// flags the cycle in which the TIMEOUT-th such cycle is being spent.
module memaccess_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks execute in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    r_count <= '0;
    else if (clr) r_count <= '0;
    else if (en)  r_count <= r_count + 1'b1;
  end

  // Expire during the waiting cycle itself so an ack in that same cycle wins.
  generate
    if (TIMEOUT > 0) begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
      assign expired = en && (r_count == LAST);
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/memaccess_ctrl.sv
// LC-3 memory-stage access sequencer: one LD/LDI/ST/STI command at a time,
// req/ack memory handshake, one-cycle response pulse with timeout error.
module memaccess_ctrl
  import memaccess_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] DMem_dout,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] memout
);

  state_e            r_state, w_next;
  mode_e             r_mode;
  logic [ADDR_W-1:0] r_addr, r_ptr;
  logic [DATA_W-1:0] r_data, r_memout;
  logic              r_err;
  logic              w_accept, w_ack, w_expired, w_wd_clr, w_wd_en;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_ack    = mem_req && mem_ack;
  assign w_wd_en  = mem_req && !mem_ack;
  assign w_wd_clr = !mem_req || ((r_state == S_PTR) && mem_ack);

  memaccess_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    DMem_addr  = '0;
    DMem_din   = '0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = is_indirect(mode_e'(cmd_mode)) ? S_PTR : S_ACC;
      end
      S_PTR: begin
        mem_req   = 1'b1;
        DMem_addr = r_addr;
        if (mem_ack)        w_next = S_ACC;
        else if (w_expired) w_next = S_RESP;
      end
      S_ACC: begin
        mem_req   = 1'b1;
        mem_we    = is_store(r_mode);
        DMem_addr = is_indirect(r_mode) ? r_ptr : r_addr;
        DMem_din  = is_store(r_mode) ? r_data : '0;
        if (mem_ack || w_expired) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign resp_err = resp_valid && r_err;
  assign memout   = r_memout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode   <= MODE_LD;
      r_addr   <= '0;
      r_data   <= '0;
      r_ptr    <= '0;
      r_memout <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode <= mode_e'(cmd_mode);
        r_addr <= M_Addr;
        r_data <= M_Data;
      end
      if ((r_state == S_PTR) && w_ack) r_ptr <= ADDR_W'(DMem_dout);
      // memout and the error flag change only when a response is being formed.
      if ((r_state == S_ACC) && w_ack) begin
        r_memout <= is_store(r_mode) ? '0 : DMem_dout;
        r_err    <= 1'b0;
      end else if (w_expired) begin
        r_memout <= '0;
        r_err    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/memaccess_ctrl.md
# memaccess_ctrl

Sequenced data-memory access unit for the LC-3 memory stage. It accepts one load or store command at a time through a valid/ready handshake and performs direct or indirect (pointer-then-data) accesses against a variable-latency data memory using a req/ack handshake. It returns the loaded word, or a store completion, through a one-cycle response pulse, and aborts any access whose acknowledge does not arrive within a timeout.

## Interface
- `DATA_W`, 16, data word width; pointers read from memory are truncated or zero-extended to `ADDR_W`.
- `ADDR_W`, 16, memory address width.
- `TIMEOUT`, 15, maximum cycles `mem_req` stays high without `mem_ack`; 0 disables the timeout.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_mode`  in  2  0 LD (direct read), 1 LDI (indirect read), 2 ST (direct write), 3 STI (indirect write).
- `M_Addr`  in  ADDR_W  effective address.
- `M_Data`  in  DATA_W  store data.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  1 = write, 0 = read.
- `DMem_addr`  out  ADDR_W  memory address.
- `DMem_din`  out  DATA_W  write data.
- `mem_ack`  in  1  access complete; `DMem_dout` is valid in the same cycle for reads.
- `DMem_dout`  in  DATA_W  read data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`: access timed out.
- `memout`  out  DATA_W  loaded word; 0 for stores and errors.

## Operation
- Command capture: a command is accepted when `cmd_valid && cmd_ready`. At acceptance, mode, `M_Addr` and `M_Data` are registered. Later input changes have no effect until the next command.
- States: IDLE, PTR (indirect pointer read), ACC (final read or write), RESP.
- Transitions:
  - IDLE goes to PTR on acceptance of LDI or STI, and to ACC on acceptance of LD or ST.
  - PTR goes to ACC on `mem_ack`. The pointer register captures `DMem_dout[ADDR_W-1:0]`.
  - ACC goes to RESP on `mem_ack`. For reads, `memout` captures `DMem_dout`.
  - RESP goes to IDLE unconditionally.
- PTR outputs: `mem_req`=1, `mem_we`=0, `DMem_addr`=latched `M_Addr`.
- ACC outputs:
  - `mem_req`=1.
  - `mem_we`=1 for ST/STI, 0 otherwise.
  - `DMem_addr` = pointer register for LDI/STI, latched `M_Addr` for LD/ST.
  - `DMem_din` = latched `M_Data` when writing, else 0.
- Timeout:
  - A wait counter clears on entry to PTR or ACC and increments each cycle `mem_req` is high without `mem_ack`.
  - When the counter reaches `TIMEOUT` with no ack, the FSM goes to RESP with the error flag set. `memout`=0 and `resp_err`=1.
  - The counter width is ceil(log2(TIMEOUT+1)), minimum 1.
- In RESP: `resp_valid`=1, `mem_req`=0.
- Bus outputs are never high-Z. When `mem_req`=0, `DMem_addr`, `DMem_din` and `mem_we` are 0.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `mem_req`, `mem_we`, `resp_valid` and `resp_err` 0; `DMem_addr`, `DMem_din` and `memout` 0. Internal registers are cleared.
- Reset asserted mid-access drops `mem_req` immediately and no response is issued. The memory must tolerate an abandoned request.
- All outputs are decoded from registered state or registered data, with no combinational path from `cmd_*` to outputs.
- `mem_ack` is sampled only while `mem_req`=1. Acks in IDLE or RESP are ignored.
- Latency: with acceptance at edge 0 and an ack in the first req cycle, LD/ST `resp_valid` is high in cycle 2, and LDI/STI `resp_valid` is high in cycle 3. Each extra wait cycle adds 1.
- `memout` holds its value from RESP until the next response overwrites it.
- `cmd_ready` is low from the cycle after acceptance through RESP. The earliest next acceptance is the cycle after RESP, so throughput is at most one command per 3 cycles.
- An ack in the same cycle the counter reaches `TIMEOUT`: the ack wins and no error is raised.

## Structure
- Package `memaccess_pkg` holds:
  - the mode enum `MODE_LD`, `MODE_LDI`, `MODE_ST`, `MODE_STI`;
  - the state enum `S_IDLE`, `S_PTR`, `S_ACC`, `S_RESP`.
- One sub-module, `memaccess_wdog`: the parametrised wait counter. Inputs: `clock`, `reset`, `clr`, `en`. Output: `expired`.
- Remaining logic is a single FSM plus datapath registers in `memaccess_ctrl`.

## Test plan
- Reset: assert `reset` with `mem_req` high in ACC, asynchronously. Required: `mem_req`=0 and `cmd_ready`=1 before the next edge, and no `resp_valid`.
- LD at `M_Addr`=0x3000, memory returns 0xBEEF after 2 wait cycles. Required: a single read to 0x3000, then `resp_valid` with `memout`=0xBEEF and `resp_err`=0, 4 cycles after acceptance.
- LDI at 0x3001, zero-wait memory, mem[0x3001]=0x4000 and mem[0x4000]=0x1234. Required: reads to 0x3001 then 0x4000, then `memout`=0x1234 in cycle 3.
- STI at 0x3002 with `M_Data`=0xA5A5, mem[0x3002]=0x5000. Required: a read to 0x3002 then a write with `mem_we`=1, `DMem_addr`=0x5000 and `DMem_din`=0xA5A5; `memout`=0.
- With `TIMEOUT`=15, ST and no ack ever. Required: `resp_valid` with `resp_err`=1 exactly 15 req-high cycles in, then IDLE. Repeat with the ack arriving on cycle 15: `resp_err`=0.
- Back-to-back: `cmd_valid` held high, alternating LD/ST. Required: one acceptance per 3 cycles with zero-wait memory, and `M_Addr` changes after acceptance are ignored.
